// File: rtl/switch_post_unpack.sv
// switch_post_unpack: egress cell FIFO unpacked into OUT_W-bit beats.
// Define POST_LEN_CHECK_EN to cross-check len against in_first/in_last.
module switch_post_unpack #(
  parameter int CELL_W     = 128,
  parameter int OUT_W      = 16,
  parameter int CELL_DEPTH = 256,
  parameter int BP_MARGIN  = 16,
  parameter int LEN_W      = 12
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               in_wr,
  input  logic [CELL_W-1:0]  in_din,
  input  logic               in_first,
  input  logic               in_last,
  output logic               in_bp,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic [OUT_W/8-1:0] out_keep,
  output logic               out_sop,
  output logic               out_eop,
  output logic [LEN_W-1:0]   out_len,
  output logic               out_err,
  output logic [15:0]        drop_cnt
);
  localparam int CB = CELL_W / 8;
  localparam int OB = OUT_W / 8;
  localparam int PW = $clog2(CB);
  localparam int AW = $clog2(CELL_DEPTH);
  localparam int EW = CELL_W + 2;

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DROP} st_t;
  st_t st, nxt;

  logic [EW-1:0]     mem [CELL_DEPTH];
  logic [AW:0]       wp, rp, cnt;
  logic              full, hv, pop, wr_ok;
  logic [CELL_W-1:0] h_data;
  logic              h_first, h_last;

  logic              ld, emit, start;
  logic              b_eop, b_err, b_trunc;
  logic              fin, wrap, first_beat;
  logic [LEN_W-1:0]  rem, flen, hdr_len, take;
  logic [PW-1:0]     ptr;
  logic [CELL_W-1:0] sh;
  logic [OUT_W-1:0]  raw, beat;
  logic [OB-1:0]     keep;
  logic              unused_sh;

  assign cnt   = wp - rp;
  assign full  = cnt == (AW+1)'(CELL_DEPTH);
  assign hv    = cnt != '0;
  assign wr_ok = in_wr && (!full || pop);

  assign {h_first, h_last, h_data} = mem[rp[AW-1:0]];

  assign hdr_len = LEN_W'({h_data[CELL_W-5 -: 4],
                           h_data[CELL_W-9 -: 8]});

  assign ld   = !out_valid || out_ready;
  assign fin  = rem <= LEN_W'(OB);
  assign take = fin ? rem : LEN_W'(OB);
  assign wrap = ptr == PW'(CB - OB);

  assign sh        = h_data << {ptr, 3'b000};
  assign raw       = sh[CELL_W-1 -: OUT_W];
  assign unused_sh = ^{sh[CELL_W-OUT_W-1:0], h_last};

  // Lane enables from bytes left in the frame; pad lanes read as zero
  always_comb begin
    keep = '0;
    beat = '0;
    for (int i = 0; i < OB; i++) begin
      if (!fin || LEN_W'(i) < rem) begin
        keep[OB-1-i] = 1'b1;
        beat[OUT_W-1-8*i -: 8] = raw[OUT_W-1-8*i -: 8];
      end
    end
  end

  // Cell storage, no reset needed on the array
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wp[AW-1:0]] <= {in_first, in_last, in_din};
  end

  // FIFO pointers, saturating drop counter, registered backpressure
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wp       <= '0;
      rp       <= '0;
      drop_cnt <= '0;
      in_bp    <= 1'b0;
    end else begin
      if (wr_ok) wp <= wp + (AW+1)'(1);
      if (pop)   rp <= rp + (AW+1)'(1);
      if (in_wr && !wr_ok && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 16'd1;
      in_bp <= cnt > (AW+1)'(CELL_DEPTH - BP_MARGIN);
    end
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) st <= IDLE;
    else       st <= nxt;
  end

  // Next state, pops and beat qualifiers
  always_comb begin
    nxt     = st;
    pop     = 1'b0;
    emit    = 1'b0;
    start   = 1'b0;
    b_eop   = 1'b0;
    b_err   = 1'b0;
    b_trunc = 1'b0;
    unique case (st)
      IDLE: begin
        if (hv) begin
          if (!h_first) begin
            nxt = DROP;
          end else if (hdr_len <= LEN_W'(2)) begin
            nxt = FLUSH;
          end else begin
            nxt   = STREAM;
            start = 1'b1;
          end
        end
      end
      DROP: begin
        if (hv) begin
          pop = 1'b1;
          nxt = IDLE;
        end
      end
      FLUSH: begin
        if (hv) begin
          pop = 1'b1;
`ifdef POST_LEN_CHECK_EN
          if (h_last) nxt = IDLE;
`else
          nxt = IDLE;
`endif
        end
      end
      STREAM: begin
        if (ld && hv) begin
          emit = 1'b1;
`ifdef POST_LEN_CHECK_EN
          if (ptr == '0 && h_first) begin
            b_trunc = 1'b1;
            b_eop   = 1'b1;
            b_err   = 1'b1;
            nxt     = IDLE;
          end else begin
            pop = wrap || fin;
            if (fin) begin
              b_eop = 1'b1;
              b_err = !h_last;
              nxt   = h_last ? IDLE : FLUSH;
            end else if (wrap && h_last) begin
              b_eop = 1'b1;
              b_err = 1'b1;
              nxt   = IDLE;
            end
          end
`else
          pop = wrap || fin;
          if (fin) begin
            b_eop = 1'b1;
            nxt   = IDLE;
          end
`endif
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // Output register, byte pointer and remaining-byte count
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_keep   <= '0;
      out_sop    <= 1'b0;
      out_eop    <= 1'b0;
      out_len    <= '0;
      out_err    <= 1'b0;
      rem        <= '0;
      flen       <= '0;
      ptr        <= '0;
      first_beat <= 1'b0;
    end else begin
      if (start) begin
        rem        <= hdr_len - LEN_W'(2);
        flen       <= hdr_len - LEN_W'(2);
        ptr        <= PW'(2);
        first_beat <= 1'b1;
      end
      if (emit) begin
        out_valid  <= 1'b1;
        out_data   <= b_trunc ? '0 : beat;
        out_keep   <= b_trunc ? '0 : keep;
        out_sop    <= first_beat && !b_trunc;
        out_eop    <= b_eop;
        out_err    <= b_err;
        out_len    <= flen;
        first_beat <= 1'b0;
        rem        <= rem - take;
        ptr        <= ptr + PW'(OB);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_switch_post_unpack.sv
// tb_switch_post_unpack: table vectors, corner sequences and random
// frames checked against a byte-level frame model.
`timescale 1ns/1ps
module tb_switch_post_unpack;
  localparam int CELL_W = 128;
  localparam int OUT_W  = 16;
  localparam int LEN_W  = 12;
  localparam int CB     = CELL_W / 8;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              in_wr = 1'b0;
  logic              in_first = 1'b0;
  logic              in_last = 1'b0;
  logic              out_ready = 1'b0;
  logic [CELL_W-1:0] in_din = '0;
  logic              in_bp, out_valid, out_sop, out_eop, out_err;
  logic [OUT_W-1:0]  out_data;
  logic [1:0]        out_keep;
  logic [LEN_W-1:0]  out_len;
  logic [15:0]       drop_cnt;

  switch_post_unpack #(
    .CELL_W(CELL_W), .OUT_W(OUT_W), .CELL_DEPTH(256),
    .BP_MARGIN(16), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rstn(rstn), .in_wr(in_wr), .in_din(in_din),
    .in_first(in_first), .in_last(in_last), .in_bp(in_bp),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_keep(out_keep), .out_sop(out_sop),
    .out_eop(out_eop), .out_len(out_len), .out_err(out_err),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [15:0] d; logic [1:0] k;
    logic sop, eop, err; logic [11:0] len;
  } beat_t;
  typedef struct { logic [CELL_W-1:0] d; logic f, l; } cell_t;
  typedef struct { int len; int nb; logic [1:0] lk; } vec_t;

  int    checks = 0, errors = 0;
  beat_t expq[$];
  cell_t cq[$];
  int    cyc = 0, nacc = 0, sop_cyc = 0, eop_cyc = 0, prev_eop_cyc = 0;
  int    rmode = 3;
  logic  [1:0] lastk = '0;
  logic  held = 1'b0;
  logic  [32:0] hb = '0;
  beat_t e;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Ready pattern: 0 always, 1 toggle, 2 random, 3 never
  initial forever begin
    @(posedge clk); #1;
    case (rmode)
      0: out_ready = 1'b1;
      1: out_ready = ~out_ready;
      2: out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  // Scoreboard and stall-stability monitor
  always @(negedge clk) begin
    cyc++;
    if (!rstn) begin
      held = 1'b0;
    end else begin
      if (held) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_beat", 64'({out_data, out_keep, out_sop, out_eop,
                              out_err, out_len}), 64'(hb));
      end
      if (out_valid && out_ready) begin
        nacc++;
        if (out_sop) sop_cyc = cyc;
        if (out_eop) begin
          prev_eop_cyc = eop_cyc;
          eop_cyc = cyc;
          lastk = out_keep;
        end
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_beat: got %h expected none", out_data);
        end else begin
          e = expq.pop_front();
          chk("beat", 64'({out_data, out_keep, out_sop, out_eop, out_err}),
              64'({e.d, e.k, e.sop, e.eop, e.err}));
          if (e.sop) chk("sop_len", 64'(out_len), 64'(e.len));
        end
      end
      held = out_valid && !out_ready;
      hb = {out_data, out_keep, out_sop, out_eop, out_err, out_len};
    end
  end

  // Expected beats: payload taken two bytes at a time
  task automatic model(input bq_t pl);
    beat_t b;
    int n;
    n = pl.size();
    for (int i = 0; i < n; i += 2) begin
      b.d   = {pl[i], (i + 1 < n) ? pl[i+1] : 8'h00};
      b.k   = (i + 1 < n) ? 2'b11 : 2'b10;
      b.sop = (i == 0);
      b.eop = (i + 2 >= n);
      b.err = 1'b0;
      b.len = 12'(n);
      expq.push_back(b);
    end
  endtask

  // Cell image: header, payload, random pad
  task automatic build(input bq_t pl, input bit mdl);
    logic [7:0] img[$];
    cell_t c;
    int n, len, nc;
    n = pl.size();
    len = n + 2;
    img.push_back({4'($urandom), 4'(len >> 8)});
    img.push_back(8'(len));
    foreach (pl[i]) img.push_back(pl[i]);
    nc = (img.size() + CB - 1) / CB;
    while (img.size() < nc * CB) img.push_back(8'($urandom));
    for (int ci = 0; ci < nc; ci++) begin
      c.d = '0;
      for (int k = 0; k < CB; k++) c.d[CELL_W-1-8*k -: 8] = img[ci*CB+k];
      c.f = (ci == 0);
      c.l = (ci == nc - 1);
      cq.push_back(c);
    end
    if (mdl) model(pl);
  endtask

  task automatic push_cells(input bit nobp);
    cell_t c;
    int w;
    while (cq.size() > 0) begin
      w = 0;
      while (!nobp && in_bp && w < 2000) begin
        @(posedge clk); #1; w++;
      end
      if (w >= 2000) begin
        checks++; errors++;
        $display("FAIL bp_timeout: got in_bp=1 expected release");
      end
      c = cq.pop_front();
      in_din = c.d; in_first = c.f; in_last = c.l; in_wr = 1'b1;
      @(posedge clk); #1;
    end
    in_wr = 1'b0;
  endtask

  task automatic drain(input int lim);
    int w;
    w = 0;
    while (expq.size() != 0 && w < lim) begin
      @(posedge clk); #1; w++;
    end
    chk("drain_left", 64'(expq.size()), 64'd0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; in_wr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expq.delete(); cq.delete();
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  function automatic bq_t seq_pl(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'(i + 1));
    return q;
  endfunction

  function automatic bq_t rnd_pl(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv[7];
    bq_t pl;
    cell_t oc;
    int a0, nexp;

    tv[0] = '{3, 1, 2'b10};
    tv[1] = '{4, 1, 2'b11};
    tv[2] = '{14, 6, 2'b11};
    tv[3] = '{16, 7, 2'b11};
    tv[4] = '{18, 8, 2'b11};
    tv[5] = '{35, 17, 2'b10};
    tv[6] = '{131, 65, 2'b10};

    rmode = 3;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_bp", 64'(in_bp), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_keep", 64'(out_keep), 64'd0);
    chk("rst_sop", 64'(out_sop), 64'd0);
    chk("rst_eop", 64'(out_eop), 64'd0);
    chk("rst_len", 64'(out_len), 64'd0);
    chk("rst_err", 64'(out_err), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Table vectors with out_ready held high
    rmode = 0;
    for (int t = 0; t < 7; t++) begin
      build(seq_pl(tv[t].len - 2), 1'b1);
      a0 = nacc;
      push_cells(1'b0);
      drain(2000);
      chk("tv_nbeats", 64'(nacc - a0), 64'(tv[t].nb));
      chk("tv_last_keep", 64'(lastk), 64'(tv[t].lk));
      chk("tv_no_bubble", 64'(eop_cyc - sop_cyc), 64'(tv[t].nb - 1));
    end

    // Latency from first-cell write into an idle, empty block
    build(seq_pl(4), 1'b1);
    push_cells(1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("latency_e1", 64'(out_valid), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("latency_e2", 64'(out_valid), 64'd1);
    drain(200);

    // Two back-to-back frames: one idle cycle between them
    build(seq_pl(12), 1'b1);
    build(rnd_pl(18), 1'b1);
    push_cells(1'b0);
    drain(500);
    chk("frame_gap", 64'(sop_cyc - prev_eop_cyc), 64'd2);

    // Ready toggling during a 64-byte frame
    rmode = 1;
    build(rnd_pl(64), 1'b1);
    a0 = nacc;
    push_cells(1'b0);
    drain(500);
    chk("toggle_beats", 64'(nacc - a0), 64'd32);
    rmode = 0;

    // Orphan non-first cell ahead of a valid frame
    oc.d = {4{32'($urandom)}}; oc.f = 1'b0; oc.l = 1'b0;
    cq.push_back(oc);
    build(rnd_pl(21), 1'b1);
    a0 = nacc;
    push_cells(1'b0);
    drain(500);
    chk("orphan_beats", 64'(nacc - a0), 64'd11);

    // Header-only frame emits nothing; next frame intact
    build(seq_pl(0), 1'b0);
    build(seq_pl(10), 1'b1);
    a0 = nacc;
    push_cells(1'b0);
    drain(500);
    chk("hdr_only_beats", 64'(nacc - a0), 64'd5);

    // Reset in the middle of a stalled frame
    rmode = 3;
    build(rnd_pl(64), 1'b0);
    push_cells(1'b0);
    repeat (3) @(posedge clk);
    #1;
    do_reset();
    chk("midrst_valid", 64'(out_valid), 64'd0);
    rmode = 0;
    build(rnd_pl(30), 1'b1);
    a0 = nacc;
    push_cells(1'b0);
    drain(500);
    chk("midrst_beats", 64'(nacc - a0), 64'd15);

    // Fill past depth with the output stalled
    rmode = 3;
    do_reset();
    for (int i = 0; i < 240; i++) build(seq_pl(12), 1'b0);
    push_cells(1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("bp_at_240", 64'(in_bp), 64'd0);
    build(seq_pl(12), 1'b0);
    push_cells(1'b1);
    chk("bp_reg_delay", 64'(in_bp), 64'd0);
    @(posedge clk); #1;
    chk("bp_at_241", 64'(in_bp), 64'd1);
    for (int i = 0; i < 18; i++) build(seq_pl(12), 1'b0);
    push_cells(1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("drop_cnt_3", 64'(drop_cnt), 64'd3);
    chk("bp_full", 64'(in_bp), 64'd1);
    do_reset();
    chk("drop_after_rst", 64'(drop_cnt), 64'd0);
    chk("bp_after_rst", 64'(in_bp), 64'd0);

`ifdef POST_LEN_CHECK_EN
    // len says 3 cells but in_last arrives on cell 2
    rmode = 0;
    pl = seq_pl(38);
    build(pl, 1'b0);
    void'(cq.pop_back());
    cq[1].l = 1'b1;
    pl = pl[0:29];
    model(pl);
    expq[expq.size()-1].err = 1'b1;
    build(rnd_pl(9), 1'b1);
    push_cells(1'b0);
    drain(500);
`endif

    // Random frames, random ready, occasional orphans
    rmode = 2;
    nexp = 0;
    a0 = nacc;
    for (int f = 0; f < 30; f++) begin
      if ($urandom_range(0, 4) == 0) begin
        oc.d = {4{32'($urandom)}}; oc.f = 1'b0; oc.l = 1'b0;
        cq.push_back(oc);
      end
      pl = rnd_pl($urandom_range(1, 120));
      nexp += (pl.size() + 1) / 2;
      build(pl, 1'b1);
      push_cells(1'b0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    drain(20000);
    chk("rand_beats", 64'(nacc - a0), 64'(nexp));
    chk("rand_drop", 64'(drop_cnt), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
